// File: rtl/alu_decode_stage.sv
// alu_decode_stage
// Decode stage for the RV32I integer compute subset (OP, OP-IMM, LUI, AUIPC).
// Produces the ALU control code, operand selects, register indices and the
// immediate from a fetched instruction. The result is held in a single output
// register with a valid/ready handshake on both sides.
// Unsupported encodings are still passed downstream, flagged as illegal, so
// that the trap logic can see them.

module alu_decode_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_ctrl,
    output logic            src_a_pc,
    output logic            src_b_imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc_q,
    output logic            reg_write,
    output logic            illegal
);

    // Full 7-bit major opcodes. Bits [1:0] are compared as well, so any word
    // whose low two bits are not 2'b11 falls through to the illegal default.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] CTRL_ADD    = 4'b0000;
    localparam logic [3:0] CTRL_SLL    = 4'b0001;
    localparam logic [3:0] CTRL_SRL    = 4'b0101;
    localparam logic [3:0] CTRL_SRA    = 4'b1101;
    localparam logic [3:0] CTRL_PASS_B = 4'b1111;

    // Instruction fields
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;

    // Decoded bundle, before the output register
    logic [3:0]      w_ctrl;
    logic            w_src_a_pc;
    logic            w_src_b_imm;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic            w_reg_write;

    // Handshake
    logic w_in_ready;
    logic w_load;

    // Output register
    logic            r_valid;
    logic [3:0]      r_ctrl;
    logic            r_src_a_pc;
    logic            r_src_b_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic            r_reg_write;
    logic            r_illegal;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_rs1    = instr[19:15];
    assign w_rs2    = instr[24:20];
    assign w_rd     = instr[11:7];

    // The stage accepts new work whenever the held bundle is empty or is
    // being consumed this cycle. A flush suppresses the load.
    assign w_in_ready = !r_valid || out_ready;
    assign w_load     = in_valid && w_in_ready && !flush;

    // Instruction decode: ALU control, operand selects, immediate and legality
    always_comb begin
        w_ctrl      = CTRL_ADD;
        w_src_a_pc  = 1'b0;
        w_src_b_imm = 1'b0;
        w_imm       = '0;
        w_illegal   = 1'b0;

        case (w_opcode)
            OPC_OP: begin
                if (w_funct7 == F7_ZERO) begin
                    w_ctrl = {1'b0, w_funct3};
                end else if (w_funct7 == F7_ALT &&
                             (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
                    w_ctrl = {1'b1, w_funct3};
                end else begin
                    w_illegal = 1'b1;
                end
            end

            OPC_OP_IMM: begin
                w_src_b_imm = 1'b1;
                w_imm       = {{(XLEN-12){instr[31]}}, instr[31:20]};
                case (w_funct3)
                    3'b001: begin
                        if (w_funct7 == F7_ZERO) begin
                            w_ctrl = CTRL_SLL;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    3'b101: begin
                        if (w_funct7 == F7_ZERO) begin
                            w_ctrl = CTRL_SRL;
                        end else if (w_funct7 == F7_ALT) begin
                            w_ctrl = CTRL_SRA;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    // Non-shift immediates use instr[31:25] as immediate bits.
                    default: w_ctrl = {1'b0, w_funct3};
                endcase
            end

            OPC_LUI: begin
                w_ctrl      = CTRL_PASS_B;
                w_src_b_imm = 1'b1;
                w_imm       = {instr[31:12], 12'b0};
            end

            OPC_AUIPC: begin
                w_ctrl      = CTRL_ADD;
                w_src_a_pc  = 1'b1;
                w_src_b_imm = 1'b1;
                w_imm       = {instr[31:12], 12'b0};
            end

            default: begin
                w_illegal = 1'b1;
            end
        endcase

        // An illegal bundle carries a neutral payload so execute does nothing
        // harmful with it before the trap is taken.
        if (w_illegal) begin
            w_ctrl      = CTRL_ADD;
            w_src_a_pc  = 1'b0;
            w_src_b_imm = 1'b0;
            w_imm       = '0;
        end
    end

    assign w_reg_write = !w_illegal && (w_rd != 5'd0);

    // Valid flag: flush clears it, a load sets it, and a consumed bundle clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Bundle register: captures the decode on load and holds it otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl      <= '0;
            r_src_a_pc  <= 1'b0;
            r_src_b_imm <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_load) begin
            r_ctrl      <= w_ctrl;
            r_src_a_pc  <= w_src_a_pc;
            r_src_b_imm <= w_src_b_imm;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_imm       <= w_imm;
            r_pc        <= pc;
            r_reg_write <= w_reg_write;
            r_illegal   <= w_illegal;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign alu_ctrl  = r_ctrl;
    assign src_a_pc  = r_src_a_pc;
    assign src_b_imm = r_src_b_imm;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign rd        = r_rd;
    assign imm       = r_imm;
    assign pc_q      = r_pc;
    assign reg_write = r_reg_write;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage
// Directed-vector bench for alu_decode_stage with hand-computed expectations.

module tb_alu_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic        src_a_pc;
    logic        src_b_imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc_q;
    logic        reg_write;
    logic        illegal;

    int n_vec;
    int n_err;

    alu_decode_stage #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a_pc  (src_a_pc),
        .src_b_imm (src_b_imm),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .pc_q      (pc_q),
        .reg_write (reg_write),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = 32'h0000_0013;
        pc        = 32'h0000_0000;

        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu_ctrl",  {28'd0, alu_ctrl},  32'd0);
        check("rst_imm",       imm,                32'd0);
        check("rst_pc_q",      pc_q,               32'd0);
        check("rst_rd",        {27'd0, rd},        32'd0);
        check("rst_illegal",   {31'd0, illegal},   32'd0);
        check("rst_reg_write", {31'd0, reg_write}, 32'd0);
        #2 rst = 1'b0;
        step();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // add x3,x1,x2
        in_valid = 1'b1; instr = 32'h0020_81B3; pc = 32'h0000_0100;
        step();
        check("add_valid",     {31'd0, out_valid}, 32'd1);
        check("add_ctrl",      {28'd0, alu_ctrl},  32'h0);
        check("add_rs1",       {27'd0, rs1},       32'd1);
        check("add_rs2",       {27'd0, rs2},       32'd2);
        check("add_rd",        {27'd0, rd},        32'd3);
        check("add_src_b",     {31'd0, src_b_imm}, 32'd0);
        check("add_reg_write", {31'd0, reg_write}, 32'd1);
        check("add_illegal",   {31'd0, illegal},   32'd0);
        check("add_pc_q",      pc_q,               32'h0000_0100);

        // sub x5,x6,x7 then srai x1,x2,3, back to back
        instr = 32'h4073_02B3; pc = 32'h0000_0104;
        step();
        check("sub_valid", {31'd0, out_valid}, 32'd1);
        check("sub_ctrl",  {28'd0, alu_ctrl},  32'h8);
        check("sub_rd",    {27'd0, rd},        32'd5);
        instr = 32'h4031_5093; pc = 32'h0000_0108;
        step();
        check("srai_valid", {31'd0, out_valid}, 32'd1);
        check("srai_ctrl",  {28'd0, alu_ctrl},  32'hD);
        check("srai_imm",   imm,                32'h0000_0403);
        check("srai_src_b", {31'd0, src_b_imm}, 32'd1);

        // addi x1,x0,-1 then lui x1,0x12345
        instr = 32'hFFF0_0093;
        step();
        check("addi_ctrl", {28'd0, alu_ctrl}, 32'h0);
        check("addi_imm",  imm,               32'hFFFF_FFFF);
        instr = 32'h1234_50B7;
        step();
        check("lui_ctrl",  {28'd0, alu_ctrl}, 32'hF);
        check("lui_imm",   imm,               32'h1234_5000);
        check("lui_src_b", {31'd0, src_b_imm}, 32'd1);

        // auipc x1,0x1 selects pc as operand A
        instr = 32'h0000_1097; pc = 32'h0000_0200;
        step();
        check("auipc_ctrl",  {28'd0, alu_ctrl}, 32'h0);
        check("auipc_src_a", {31'd0, src_a_pc}, 32'd1);
        check("auipc_imm",   imm,               32'h0000_1000);
        check("auipc_pc_q",  pc_q,              32'h0000_0200);

        // andi x1,x1,-1: the upper immediate bits are not a funct7
        instr = 32'hFFF0_F093;
        step();
        check("andi_ctrl",    {28'd0, alu_ctrl}, 32'h7);
        check("andi_illegal", {31'd0, illegal},  32'd0);

        // add x0,x1,x2 is legal but does not write back
        instr = 32'h0020_8033;
        step();
        check("add_x0_reg_write", {31'd0, reg_write}, 32'd0);
        check("add_x0_illegal",   {31'd0, illegal},   32'd0);

        // xor with funct7=0100000 is illegal
        instr = 32'h4020_C1B3;
        step();
        check("xor_alt_valid",     {31'd0, out_valid}, 32'd1);
        check("xor_alt_illegal",   {31'd0, illegal},   32'd1);
        check("xor_alt_reg_write", {31'd0, reg_write}, 32'd0);
        check("xor_alt_ctrl",      {28'd0, alu_ctrl},  32'h0);

        // slli with funct7=0100000 is illegal
        instr = 32'h4020_9093;
        step();
        check("slli_alt_illegal", {31'd0, illegal},   32'd1);
        check("slli_alt_imm",     imm,                32'd0);
        check("slli_alt_src_b",   {31'd0, src_b_imm}, 32'd0);

        // low bits != 2'b11 is illegal
        instr = 32'h0020_81B0;
        step();
        check("lowbits_illegal", {31'd0, illegal}, 32'd1);

        // Backpressure: add loaded, then lui presented while out_ready=0
        instr = 32'h0020_81B3;
        step();
        check("bp_add_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        instr = 32'h1234_50B7;
        #1;
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_valid",    {31'd0, out_valid}, 32'd1);
            check("bp_hold_ctrl",     {28'd0, alu_ctrl},  32'h0);
            check("bp_hold_rd",       {27'd0, rd},        32'd3);
            check("bp_hold_in_ready", {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_lui_valid", {31'd0, out_valid}, 32'd1);
        check("bp_lui_ctrl",  {28'd0, alu_ctrl},  32'hF);
        check("bp_lui_imm",   imm,                32'h1234_5000);
        in_valid = 1'b0;
        step();
        check("bp_no_dup", {31'd0, out_valid}, 32'd0);

        // Flush together with a valid load: nothing loads
        in_valid = 1'b1; instr = 32'h0020_81B3;
        step();
        check("fl_pre_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1; instr = 32'h1234_50B7;
        step();
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_ctrl_kept", {28'd0, alu_ctrl}, 32'h0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("fl_after_valid", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a stall clears without a clock edge
        in_valid = 1'b1; instr = 32'h0020_81B3; out_ready = 1'b0;
        step();
        check("rs_stall_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rs_async_valid", {31'd0, out_valid}, 32'd0);
        check("rs_async_rd",    {27'd0, rd},        32'd0);
        check("rs_async_rs1",   {27'd0, rs1},       32'd0);
        check("rs_async_rw",    {31'd0, reg_write}, 32'd0);
        step();
        #2 rst = 1'b0;
        step();
        check("rs_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("rs_release_valid",    {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
